// File: rtl/arm7_regfile_pkg.sv
// ---------------------------------------------------------------------------
// arm7_regfile_pkg
//   Shared definitions for the ARM7 register file: processor mode encodings,
//   reset CPSR value, physical-slot and SPSR-select types, and the helpers
//   that resolve (mode, architectural index) to a physical storage slot.
//
//   Optional feature macro: REGFILE_BANKING_EN
//     defined     -> per-mode banked registers and SPSRs (31 physical slots)
//     not defined -> flat 16-register file, no SPSRs
//
//   Physical slot layout with banking enabled:
//     0-15  USR/SYS R0-R15 (R15 shared by every mode)
//     16-22 FIQ R8-R14
//     23-24 IRQ R13-R14   25-26 SVC R13-R14
//     27-28 ABT R13-R14   29-30 UND R13-R14
// ---------------------------------------------------------------------------
package arm7_regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

  localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

  localparam int NUM_SPSR = 5;

`ifdef REGFILE_BANKING_EN
  localparam bit BANKING_EN = 1'b1;
  localparam int PHYS_W     = 5;
  localparam int NUM_PHYS   = 31;
`else
  localparam bit BANKING_EN = 1'b0;
  localparam int PHYS_W     = 4;
  localparam int NUM_PHYS   = 16;
`endif

  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [2:0]        spsr_idx_t;

  typedef struct packed {
    logic      valid;
    spsr_idx_t idx;
  } spsr_sel_t;

  localparam spsr_idx_t SPSR_FIQ = 3'd0;
  localparam spsr_idx_t SPSR_IRQ = 3'd1;
  localparam spsr_idx_t SPSR_SVC = 3'd2;
  localparam spsr_idx_t SPSR_ABT = 3'd3;
  localparam spsr_idx_t SPSR_UND = 3'd4;

  // Which SPSR (if any) belongs to a mode. USR, SYS and undefined encodings
  // own none; in the flat build no mode owns one.
  function automatic spsr_sel_t spsr_lookup(input logic [4:0] mode);
    spsr_sel_t sel;
    sel.valid = 1'b1;
    sel.idx   = SPSR_FIQ;
    case (mode)
      MODE_FIQ: sel.idx = SPSR_FIQ;
      MODE_IRQ: sel.idx = SPSR_IRQ;
      MODE_SVC: sel.idx = SPSR_SVC;
      MODE_ABT: sel.idx = SPSR_ABT;
      MODE_UND: sel.idx = SPSR_UND;
      default: begin
        sel.valid = 1'b0;
        sel.idx   = SPSR_FIQ;
      end
    endcase
    sel.valid = sel.valid & BANKING_EN;
    return sel;
  endfunction

`ifdef REGFILE_BANKING_EN
  // Resolve an architectural register index to its physical slot in the
  // given mode. R15 never banks; FIQ banks R8-R14; the other exception
  // modes bank R13-R14 only.
  function automatic phys_idx_t map_phys(input logic [4:0] mode, input logic [3:0] idx);
    phys_idx_t slot;
    phys_idx_t base;
    logic      r13_14;
    r13_14 = (idx == 4'd13) || (idx == 4'd14);
    case (mode)
      MODE_IRQ: base = 5'd23;
      MODE_SVC: base = 5'd25;
      MODE_ABT: base = 5'd27;
      MODE_UND: base = 5'd29;
      default:  base = 5'd0;
    endcase
    if ((mode == MODE_FIQ) && (idx >= 4'd8) && (idx <= 4'd14)) begin
      slot = {1'b0, idx} + 5'd8;
    end else if (r13_14 && (base != 5'd0)) begin
      // R13 -> base, R14 -> base+1 (idx[0] is 1 for R13, 0 for R14)
      slot = base + {4'b0000, ~idx[0]};
    end else begin
      slot = {1'b0, idx};
    end
    return slot;
  endfunction
`endif

endpackage

// File: rtl/arm7_bank_sel.sv
// ---------------------------------------------------------------------------
// arm7_bank_sel
//   Combinational bank resolution for the ARM7 register file.
//   Optional feature macro: REGFILE_BANKING_EN (flat mapping when undefined).
//
//   Ports
//     cur_mode        in   5  mode from current CPSR[4:0]
//     new_mode        in   5  mode field of an incoming CPSR write
//     read_reg        in   4  architectural read index
//     write_reg       in   4  architectural write index
//     read_slot       out  W  physical slot for read_reg in cur_mode
//     write_slot      out  W  physical slot for write_reg in cur_mode
//     cur_spsr_valid  out  1  cur_mode owns an SPSR
//     cur_spsr_idx    out  3  which SPSR cur_mode owns
//     new_spsr_valid  out  1  new_mode owns an SPSR
//     new_spsr_idx    out  3  which SPSR new_mode owns
// ---------------------------------------------------------------------------
module arm7_bank_sel
  import arm7_regfile_pkg::*;
(
  input  logic [4:0]        cur_mode,
  input  logic [4:0]        new_mode,
  input  logic [3:0]        read_reg,
  input  logic [3:0]        write_reg,
  output logic [PHYS_W-1:0] read_slot,
  output logic [PHYS_W-1:0] write_slot,
  output logic              cur_spsr_valid,
  output logic [2:0]        cur_spsr_idx,
  output logic              new_spsr_valid,
  output logic [2:0]        new_spsr_idx
);

  spsr_sel_t cur_sel_s;
  spsr_sel_t new_sel_s;

  // Resolve read/write indices to physical slots for the current mode
  always_comb begin
`ifdef REGFILE_BANKING_EN
    read_slot  = map_phys(cur_mode, read_reg);
    write_slot = map_phys(cur_mode, write_reg);
`else
    read_slot  = read_reg;
    write_slot = write_reg;
`endif
  end

  // Decode SPSR ownership of the current and the incoming mode
  always_comb begin
    cur_sel_s      = spsr_lookup(cur_mode);
    new_sel_s      = spsr_lookup(new_mode);
    cur_spsr_valid = cur_sel_s.valid;
    cur_spsr_idx   = cur_sel_s.idx;
    new_spsr_valid = new_sel_s.valid;
    new_spsr_idx   = new_sel_s.idx;
  end

endmodule

// File: rtl/arm7_register_file.sv
// ---------------------------------------------------------------------------
// arm7_register_file
//   ARM7 architectural register file: R0-R15 with per-mode banking, CPSR and
//   per-mode SPSRs. One registered read port, one write port, one CPSR
//   read/write port. The current mode is always CPSR[4:0].
//   Optional feature macro: REGFILE_BANKING_EN (flat 16 registers, no SPSRs
//   when undefined).
//
//   Parameters
//     RESET_CPSR  CPSR value after reset (default SVC, I and F set)
//
//   Ports
//     clk                      in   1   rising-edge clock
//     rst                      in   1   asynchronous active-high reset
//     write_en                 in   1   write write_value to write_reg
//     write_reg                in   4   destination index
//     write_value              in   32  write data
//     write_restore_from_SPSR  in   1   with an R15 write, copy SPSR to CPSR
//     read_en                  in   1   capture read_reg into read_value
//     read_reg                 in   4   source index
//     read_value               out  32  registered read data
//     cpsr_read_en             in   1   capture CPSR into cpsr_read_value
//     cpsr_read_value          out  32  registered CPSR read data
//     cpsr_write_en            in   1   write cpsr_write_value to CPSR
//     cpsr_write_value         in   32  CPSR write data
// ---------------------------------------------------------------------------
module arm7_register_file
  import arm7_regfile_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR = RESET_CPSR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value
);

  logic [31:0]       gpr_r  [NUM_PHYS];
  logic [31:0]       spsr_r [NUM_SPSR];
  logic [31:0]       cpsr_r;
  logic [31:0]       cpsr_next_s;
  logic [4:0]        cur_mode_s;
  logic [4:0]        new_mode_s;
  logic [PHYS_W-1:0] read_slot_s;
  logic [PHYS_W-1:0] write_slot_s;
  logic              cur_spsr_valid_s;
  logic [2:0]        cur_spsr_idx_s;
  logic              new_spsr_valid_s;
  logic [2:0]        new_spsr_idx_s;
  logic              restore_s;
  logic              spsr_save_s;

  // All bank resolution uses the pre-edge mode, so a same-cycle CPSR
  // write never redirects the register write or read.
  assign cur_mode_s = cpsr_r[4:0];
  assign new_mode_s = cpsr_write_value[4:0];

  arm7_bank_sel u_bank_sel (
    .cur_mode       (cur_mode_s),
    .new_mode       (new_mode_s),
    .read_reg       (read_reg),
    .write_reg      (write_reg),
    .read_slot      (read_slot_s),
    .write_slot     (write_slot_s),
    .cur_spsr_valid (cur_spsr_valid_s),
    .cur_spsr_idx   (cur_spsr_idx_s),
    .new_spsr_valid (new_spsr_valid_s),
    .new_spsr_idx   (new_spsr_idx_s)
  );

  // Exception return: only meaningful when the current mode owns an SPSR
  assign restore_s = write_en && (write_reg == 4'd15) &&
                     write_restore_from_SPSR && cur_spsr_valid_s;

  // Next CPSR and SPSR save decision; an explicit CPSR write wins over restore
  always_comb begin
    cpsr_next_s = cpsr_r;
    spsr_save_s = 1'b0;
    if (cpsr_write_en) begin
      cpsr_next_s = cpsr_write_value;
      if (new_spsr_valid_s && (new_mode_s != cur_mode_s)) begin
        spsr_save_s = 1'b1;
      end else begin
        spsr_save_s = 1'b0;
      end
    end else if (restore_s) begin
      cpsr_next_s = spsr_r[cur_spsr_idx_s];
    end else begin
      cpsr_next_s = cpsr_r;
    end
  end

  // General-purpose and banked register storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        gpr_r[i] <= 32'h0000_0000;
      end
    end else if (write_en) begin
      gpr_r[write_slot_s] <= write_value;
    end
  end

  // Saved program status registers, loaded on entry to an exception mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPSR; i++) begin
        spsr_r[i] <= 32'h0000_0000;
      end
    end else if (spsr_save_s) begin
      spsr_r[new_spsr_idx_s] <= cpsr_r;
    end
  end

  // Current program status register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpsr_r <= RESET_CPSR;
    end else begin
      cpsr_r <= cpsr_next_s;
    end
  end

  // Registered read ports; sample pre-edge contents and hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_value      <= 32'h0000_0000;
      cpsr_read_value <= 32'h0000_0000;
    end else begin
      if (read_en) begin
        read_value <= gpr_r[read_slot_s];
      end
      if (cpsr_read_en) begin
        cpsr_read_value <= cpsr_r;
      end
    end
  end

endmodule

// File: tb/tb_arm7_register_file.sv
// ---------------------------------------------------------------------------
// tb_arm7_register_file
//   Self-checking bench for arm7_register_file. Directed scenarios plus a
//   randomized run compared against a behavioural model of the architectural
//   state (registers keyed by owning bank, SPSRs keyed by mode).
//   Honours REGFILE_BANKING_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_arm7_register_file;

`ifdef REGFILE_BANKING_EN
  localparam bit BANKED = 1'b1;
`else
  localparam bit BANKED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [31:0] write_value;
  logic        write_restore_from_SPSR;
  logic        read_en;
  logic [3:0]  read_reg;
  logic [31:0] read_value;
  logic        cpsr_read_en;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_write_value;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  arm7_register_file dut (
    .clk                     (clk),
    .rst                     (rst),
    .write_en                (write_en),
    .write_reg               (write_reg),
    .write_value             (write_value),
    .write_restore_from_SPSR (write_restore_from_SPSR),
    .read_en                 (read_en),
    .read_reg                (read_reg),
    .read_value              (read_value),
    .cpsr_read_en            (cpsr_read_en),
    .cpsr_read_value         (cpsr_read_value),
    .cpsr_write_en           (cpsr_write_en),
    .cpsr_write_value        (cpsr_write_value)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_reg  [int];
  logic [31:0] m_spsr [int];
  logic [31:0] m_cpsr;
  logic [31:0] m_rv;
  logic [31:0] m_crv;

  function automatic bit is_exc(input logic [4:0] mode);
    return BANKED && (mode == 5'h11 || mode == 5'h12 || mode == 5'h13 ||
                      mode == 5'h17 || mode == 5'h1B);
  endfunction

  // bank 0 = shared USR/SYS set, 1 = FIQ high regs, otherwise the mode value
  function automatic int reg_key(input logic [4:0] mode, input logic [3:0] r);
    int bank;
    bank = 0;
    if (BANKED && r != 4'd15) begin
      if (mode == 5'h11 && r >= 4'd8) bank = 1;
      else if (is_exc(mode) && (r == 4'd13 || r == 4'd14)) bank = 32 + int'(mode);
    end
    return bank * 16 + int'(r);
  endfunction

  function automatic logic [31:0] m_get(input logic [4:0] mode, input logic [3:0] r);
    int k;
    k = reg_key(mode, r);
    return m_reg.exists(k) ? m_reg[k] : 32'h0;
  endfunction

  function automatic void model_reset();
    m_reg.delete();
    m_spsr.delete();
    m_cpsr = 32'h0000_00D3;
    m_rv   = 32'h0;
    m_crv  = 32'h0;
  endfunction

  function automatic void model_step(input logic we, input logic [3:0] wr, input logic [31:0] wv,
                                     input logic rs, input logic re, input logic [3:0] rr,
                                     input logic cre, input logic cwe, input logic [31:0] cwv);
    logic [31:0] old_cpsr;
    logic [4:0]  old_mode;
    old_cpsr = m_cpsr;
    old_mode = m_cpsr[4:0];
    if (re)  m_rv  = m_get(old_mode, rr);
    if (cre) m_crv = old_cpsr;
    if (we)  m_reg[reg_key(old_mode, wr)] = wv;
    if (cwe) begin
      if (is_exc(cwv[4:0]) && cwv[4:0] != old_mode) m_spsr[int'(cwv[4:0])] = old_cpsr;
      m_cpsr = cwv;
    end else if (we && wr == 4'd15 && rs && is_exc(old_mode)) begin
      m_cpsr = m_spsr.exists(int'(old_mode)) ? m_spsr[int'(old_mode)] : 32'h0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    write_en = 1'b0; write_reg = 4'd0; write_value = 32'h0; write_restore_from_SPSR = 1'b0;
    read_en = 1'b0; read_reg = 4'd0; cpsr_read_en = 1'b0;
    cpsr_write_en = 1'b0; cpsr_write_value = 32'h0;
  endtask

  task automatic do_cycle(input logic we, input logic [3:0] wr, input logic [31:0] wv,
                          input logic rs, input logic re, input logic [3:0] rr,
                          input logic cre, input logic cwe, input logic [31:0] cwv);
    write_en = we; write_reg = wr; write_value = wv; write_restore_from_SPSR = rs;
    read_en = re; read_reg = rr; cpsr_read_en = cre;
    cpsr_write_en = cwe; cpsr_write_value = cwv;
    model_step(we, wr, wv, rs, re, rr, cre, cwe, cwv);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [31:0] v, input logic rs);
    do_cycle(1'b1, r, v, rs, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd_reg(input logic [3:0] r);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, r, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic cpsr_wr(input logic [31:0] v);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, v);
  endtask

  task automatic cpsr_rd();
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cnt++;
    if (read_value !== 32'h0) $display("FAIL reset_read_value got %h exp %h", read_value, 32'h0);
    else pass_cnt++;
    chk_cnt++;
    if (cpsr_read_value !== 32'h0) $display("FAIL reset_cpsr_read_value got %h exp %h", cpsr_read_value, 32'h0);
    else pass_cnt++;
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'h0000_00D3) $display("FAIL reset_cpsr got %h exp %h", cpsr_read_value, 32'h0000_00D3);
    else pass_cnt++;
    rd_reg(4'd15);
    chk_cnt++;
    if (read_value !== 32'h0) $display("FAIL reset_r15 got %h exp %h", read_value, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    wr_reg(4'd4, 32'hDEAD_BEEF, 1'b0);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
    rd_reg(4'd4);
    chk_cnt++;
    if (read_value !== 32'hDEAD_BEEF) $display("FAIL wr_rd_r4 got %h exp %h", read_value, 32'hDEAD_BEEF);
    else pass_cnt++;
    // read_value holds while read_en is low
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0);
    chk_cnt++;
    if (read_value !== 32'hDEAD_BEEF) $display("FAIL rd_hold got %h exp %h", read_value, 32'hDEAD_BEEF);
    else pass_cnt++;
    // same-cycle read and write of the same register returns the old value
    do_cycle(1'b1, 4'd4, 32'h1111_2222, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 32'h0);
    chk_cnt++;
    if (read_value !== 32'hDEAD_BEEF) $display("FAIL rw_same_old got %h exp %h", read_value, 32'hDEAD_BEEF);
    else pass_cnt++;
    rd_reg(4'd4);
    chk_cnt++;
    if (read_value !== 32'h1111_2222) $display("FAIL rw_same_new got %h exp %h", read_value, 32'h1111_2222);
    else pass_cnt++;
  endtask

  task automatic test_banking();
    logic [31:0] exp13;
    logic [31:0] exp14;
    wr_reg(4'd13, 32'h0000_1000, 1'b0);
    wr_reg(4'd14, 32'h0000_2000, 1'b0);
    rd_reg(4'd13);
    chk_cnt++;
    if (read_value !== 32'h0000_1000) $display("FAIL svc_r13 got %h exp %h", read_value, 32'h0000_1000);
    else pass_cnt++;
    rd_reg(4'd14);
    chk_cnt++;
    if (read_value !== 32'h0000_2000) $display("FAIL svc_r14 got %h exp %h", read_value, 32'h0000_2000);
    else pass_cnt++;
    cpsr_wr(32'h0000_0010);
    exp13 = BANKED ? 32'h0 : 32'h0000_1000;
    exp14 = BANKED ? 32'h0 : 32'h0000_2000;
    rd_reg(4'd13);
    chk_cnt++;
    if (read_value !== exp13) $display("FAIL usr_r13 got %h exp %h", read_value, exp13);
    else pass_cnt++;
    rd_reg(4'd14);
    chk_cnt++;
    if (read_value !== exp14) $display("FAIL usr_r14 got %h exp %h", read_value, exp14);
    else pass_cnt++;
    cpsr_wr(32'h0000_00D3);
    rd_reg(4'd13);
    chk_cnt++;
    if (read_value !== 32'h0000_1000) $display("FAIL svc_back_r13 got %h exp %h", read_value, 32'h0000_1000);
    else pass_cnt++;
    rd_reg(4'd14);
    chk_cnt++;
    if (read_value !== 32'h0000_2000) $display("FAIL svc_back_r14 got %h exp %h", read_value, 32'h0000_2000);
    else pass_cnt++;
  endtask

  task automatic test_pc_write();
    wr_reg(4'd15, 32'h0000_3004, 1'b0);
    rd_reg(4'd15);
    chk_cnt++;
    if (read_value !== 32'h0000_3004) $display("FAIL pc_read got %h exp %h", read_value, 32'h0000_3004);
    else pass_cnt++;
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'h0000_00D3) $display("FAIL pc_cpsr_unchanged got %h exp %h", cpsr_read_value, 32'h0000_00D3);
    else pass_cnt++;
  endtask

  task automatic test_cpsr_rw();
    cpsr_wr(32'hCAFE_BABE);
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'hCAFE_BABE) $display("FAIL cpsr_rw got %h exp %h", cpsr_read_value, 32'hCAFE_BABE);
    else pass_cnt++;
  endtask

  task automatic test_restore();
    logic [31:0] exp_c;
    cpsr_wr(32'h0000_0010);
    cpsr_wr(32'h0000_0012);
    wr_reg(4'd15, 32'h0000_4000, 1'b1);
    cpsr_rd();
    exp_c = BANKED ? 32'h0000_0010 : 32'h0000_0012;
    chk_cnt++;
    if (cpsr_read_value !== exp_c) $display("FAIL restore_cpsr got %h exp %h", cpsr_read_value, exp_c);
    else pass_cnt++;
    rd_reg(4'd15);
    chk_cnt++;
    if (read_value !== 32'h0000_4000) $display("FAIL restore_pc got %h exp %h", read_value, 32'h0000_4000);
    else pass_cnt++;
    // CPSR write wins over a restore in the same cycle
    cpsr_wr(32'h0000_0012);
    do_cycle(1'b1, 4'd15, 32'h0000_5000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 32'h0000_00D3);
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'h0000_00D3) $display("FAIL restore_priority got %h exp %h", cpsr_read_value, 32'h0000_00D3);
    else pass_cnt++;
    // restore from a mode without an SPSR leaves CPSR alone
    cpsr_wr(32'h0000_0010);
    wr_reg(4'd15, 32'h0000_6000, 1'b1);
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'h0000_0010) $display("FAIL restore_usr_noop got %h exp %h", cpsr_read_value, 32'h0000_0010);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic        we, rs, re, cre, cwe;
    logic [3:0]  wr, rr;
    logic [31:0] wv, cwv;
    logic [4:0]  md;
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 15));
      wv  = $urandom();
      rs  = ($urandom_range(0, 2) == 0);
      re  = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 15));
      cre = 1'($urandom_range(0, 1));
      cwe = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0: md = 5'h10;
        1: md = 5'h11;
        2: md = 5'h12;
        3: md = 5'h13;
        4: md = 5'h17;
        5: md = 5'h1B;
        6: md = 5'h1F;
        default: md = 5'($urandom());
      endcase
      cwv = $urandom();
      cwv[4:0] = md;
      do_cycle(we, wr, wv, rs, re, rr, cre, cwe, cwv);
      chk_cnt++;
      if (read_value !== m_rv) $display("FAIL rand_read n=%0d got %h exp %h", n, read_value, m_rv);
      else pass_cnt++;
      chk_cnt++;
      if (cpsr_read_value !== m_crv) $display("FAIL rand_cpsr n=%0d got %h exp %h", n, cpsr_read_value, m_crv);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    cpsr_wr(32'h0000_00DF);
    wr_reg(4'd4, 32'hDEAD_BEEF, 1'b0);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 32'h0);
    chk_cnt++;
    if (read_value !== 32'hDEAD_BEEF) $display("FAIL pre_rst_read got %h exp %h", read_value, 32'hDEAD_BEEF);
    else pass_cnt++;
    // pending write and CPSR write in flight when reset hits mid-cycle
    write_en = 1'b1; write_reg = 4'd5; write_value = 32'h5555_5555;
    cpsr_write_en = 1'b1; cpsr_write_value = 32'h0000_0011;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (read_value !== 32'h0) $display("FAIL async_rst_read got %h exp %h", read_value, 32'h0);
    else pass_cnt++;
    chk_cnt++;
    if (cpsr_read_value !== 32'h0) $display("FAIL async_rst_cpsr_rd got %h exp %h", cpsr_read_value, 32'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    cpsr_rd();
    chk_cnt++;
    if (cpsr_read_value !== 32'h0000_00D3) $display("FAIL post_rst_cpsr got %h exp %h", cpsr_read_value, 32'h0000_00D3);
    else pass_cnt++;
    rd_reg(4'd5);
    chk_cnt++;
    if (read_value !== 32'h0) $display("FAIL post_rst_r5 got %h exp %h", read_value, 32'h0);
    else pass_cnt++;
    rd_reg(4'd4);
    chk_cnt++;
    if (read_value !== 32'h0) $display("FAIL post_rst_r4 got %h exp %h", read_value, 32'h0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_banking();
    test_pc_write();
    test_cpsr_rw();
    test_restore();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
